// File: rtl/rr_interconnect_pkg.sv
// Shared parameters and helpers for the round-robin packet interconnect.
package rr_interconnect_pkg;

    localparam int PACKET_WIDTH = 8;

    // Index reached by stepping 'step' places past 'base' on a ring of 'n' ports.
    function automatic int wrap_index(input int base, input int step, input int n);
        return (base + step) % n;
    endfunction

endpackage

// File: rtl/rr_interconnect_pick.sv
// Rotate-and-find-first arbiter: nearest requester after the last grant wins.
module rr_pick
    import rr_interconnect_pkg::*;
#(
    parameter int CONNECT_NUM = 3,
    parameter int INDEX_WIDTH = 2
) (
    input  logic [CONNECT_NUM-1:0] req,
    input  logic [INDEX_WIDTH-1:0] last,
    output logic [INDEX_WIDTH-1:0] grant,
    output logic                   any
);

    logic [INDEX_WIDTH-1:0] pick_idx_s;

    // Scan from the farthest offset inward so the nearest requester overrides.
    always_comb begin
        pick_idx_s = {INDEX_WIDTH{1'b0}};
        grant      = {INDEX_WIDTH{1'b0}};
        for (int k = CONNECT_NUM; k >= 1; k--) begin
            pick_idx_s = INDEX_WIDTH'(wrap_index(int'(last), k, CONNECT_NUM));
            grant      = req[pick_idx_s] ? pick_idx_s : grant;
        end
    end

    assign any = |req;

endmodule

// File: rtl/rr_interconnect.sv
// Round-robin N-to-1 packet interconnect with a single registered output slot.
module rr_interconnect
    import rr_interconnect_pkg::*;
#(
    parameter int DATA_WIDTH  = PACKET_WIDTH,
    parameter int CONNECT_NUM = 3,
    parameter int INDEX_WIDTH = 2
) (
    input  logic                              CLK,
    input  logic                              RST,
    input  logic [CONNECT_NUM-1:0]            RECEIVE_VALID,
    output logic [CONNECT_NUM-1:0]            RECEIVE_READY,
    input  logic [DATA_WIDTH*CONNECT_NUM-1:0] RECEIVE_DATA,
    output logic                              SEND_VALID,
    input  logic                              SEND_READY,
    output logic [DATA_WIDTH-1:0]             SEND_DATA,
    output logic [INDEX_WIDTH-1:0]            SEND_INDEX
);

    logic [INDEX_WIDTH-1:0] last_r;
    logic                   send_valid_r;
    logic [DATA_WIDTH-1:0]  send_data_r;
    logic [INDEX_WIDTH-1:0] send_index_r;

    logic [INDEX_WIDTH-1:0] grant_s;
    logic                   any_s;
    logic                   load_en_s;
    logic                   xfer_s;
    logic [CONNECT_NUM-1:0] ready_s;
    logic [DATA_WIDTH-1:0]  grant_data_s;

    rr_pick #(
        .CONNECT_NUM (CONNECT_NUM),
        .INDEX_WIDTH (INDEX_WIDTH)
    ) u_pick (
        .req   (RECEIVE_VALID),
        .last  (last_r),
        .grant (grant_s),
        .any   (any_s)
    );

    assign load_en_s = !send_valid_r || SEND_READY;

    // Accept goes to the granted port only, and never while reset is held.
    always_comb begin
        ready_s = {CONNECT_NUM{1'b0}};
        if (RST && any_s && load_en_s) begin
            ready_s[grant_s] = 1'b1;
        end else begin
            ready_s = {CONNECT_NUM{1'b0}};
        end
    end

    assign xfer_s = |ready_s;

    // Select the granted port's packet from the flattened input bus.
    always_comb begin
        grant_data_s = {DATA_WIDTH{1'b0}};
        for (int i = 0; i < CONNECT_NUM; i++) begin
            grant_data_s = (grant_s == INDEX_WIDTH'(i))
                         ? RECEIVE_DATA[DATA_WIDTH*i +: DATA_WIDTH]
                         : grant_data_s;
        end
    end

    // Output slot and round-robin pointer; a stalled slot freezes both.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            send_valid_r <= 1'b0;
            send_data_r  <= {DATA_WIDTH{1'b0}};
            send_index_r <= {INDEX_WIDTH{1'b0}};
            last_r       <= INDEX_WIDTH'(CONNECT_NUM - 1);
        end else if (xfer_s) begin
            send_valid_r <= 1'b1;
            send_data_r  <= grant_data_s;
            send_index_r <= grant_s;
            last_r       <= grant_s;
        end else if (SEND_READY) begin
            send_valid_r <= 1'b0;
        end
    end

    assign RECEIVE_READY = ready_s;
    assign SEND_VALID    = send_valid_r;
    assign SEND_DATA     = send_data_r;
    assign SEND_INDEX    = send_index_r;

endmodule

// File: doc/rr_interconnect.md
RR_INTERCONNECT -- requirements
Module: rr_interconnect

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default PACKET_WIDTH, width of one packet.
REQ-002 SHALL have parameter CONNECT_NUM, default 3, number of requesting ports (legal range 2..16).
REQ-003 SHALL have parameter INDEX_WIDTH, default 2, width of a port index (>= clog2(CONNECT_NUM)).
REQ-004 CLK  in  1  single clock; all state changes on rising edge.
REQ-005 RST  in  1  reset, asynchronous, active-low.
REQ-006 RECEIVE_VALID  in  CONNECT_NUM  per-port packet-valid.
REQ-007 RECEIVE_READY  out  CONNECT_NUM  per-port accept; at most one bit high per cycle.
REQ-008 RECEIVE_DATA  in  DATA_WIDTH*CONNECT_NUM  port i occupies bits [DATA_WIDTH*(i+1)-1 -: DATA_WIDTH].
REQ-009 SEND_VALID  out  1  output packet valid.
REQ-010 SEND_READY  in  1  downstream accept.
REQ-011 SEND_DATA  out  DATA_WIDTH  held output packet.
REQ-012 SEND_INDEX  out  INDEX_WIDTH  source port of the packet on SEND_DATA.

Function
REQ-013 SHALL hold one packet in an output register (SEND_VALID/SEND_DATA/SEND_INDEX all registered; no input-to-output combinational path).
REQ-014 SHALL define load_en = !SEND_VALID || SEND_READY; a new packet is accepted only when load_en is high.
REQ-015 SHALL choose grant g combinationally as the first port with RECEIVE_VALID high, searching LAST+1, LAST+2, ... modulo CONNECT_NUM, where LAST is the registered pointer.
REQ-016 SHALL drive RECEIVE_READY[g] = load_en when any RECEIVE_VALID is high; all other RECEIVE_READY bits 0; all bits 0 when no RECEIVE_VALID is high.
REQ-017 SHALL, on a transfer (RECEIVE_VALID[g] && RECEIVE_READY[g]), load SEND_DATA <= port g data, SEND_INDEX <= g, SEND_VALID <= 1, and LAST <= g, all on the same edge.
REQ-018 SHALL, when SEND_READY is high and no input transfer occurs, clear SEND_VALID on the next edge; SEND_DATA/SEND_INDEX keep their old value.
REQ-019 SHALL sustain one packet per cycle when SEND_READY stays high (drain and load in the same cycle).
REQ-020 SHALL, while SEND_VALID && !SEND_READY, keep SEND_VALID, SEND_DATA, SEND_INDEX and LAST unchanged.
REQ-021 SHALL leave LAST unchanged in cycles without a transfer, so a port that lost arbitration keeps its place.
REQ-022 SHALL wrap the pointer search from CONNECT_NUM-1 to 0; a single active port is granted every cycle.
REQ-023 SHALL ignore RECEIVE_DATA of non-granted ports; sources keep data stable while valid and not ready.
REQ-024 SHALL guarantee fairness: a port with RECEIVE_VALID held high is granted within CONNECT_NUM transfers.

Reset
REQ-025 SHALL, while RST is low, asynchronously force SEND_VALID=0, SEND_DATA=0, SEND_INDEX=0, LAST=CONNECT_NUM-1 (port 0 has first priority).
REQ-026 SHALL, while RST is low, drive all RECEIVE_READY bits 0, independent of RECEIVE_VALID.
REQ-027 SHALL drop any packet in flight on reset; no transfer is counted on the edge where RST is released.

Structure
REQ-028 SHALL take PACKET_WIDTH from the shared parameter include; no new shared typedefs.
REQ-029 SHALL put the rotate-and-find-first grant logic in one sub-module rr_pick (inputs request vector and LAST, outputs g and any-request flag).
REQ-030 SHALL be a drop-in replacement for the existing fixed-priority interconnect (same port names plus SEND_INDEX).

Verification (CONNECT_NUM=3)
REQ-031 Reset: RST=0 with all RECEIVE_VALID=1 -> RECEIVE_READY=000, SEND_VALID=0; after release, first packet from port 0.
REQ-032 All three ports valid at once, SEND_READY=1 -> SEND_INDEX 0,1,2 on three consecutive cycles, SEND_VALID first high one cycle after the first accept.
REQ-033 Ports 0 and 2 held valid, port 1 idle -> grant order 0,2,0,2; port 1 raised mid-stream after a port-0 grant -> next grant is 1.
REQ-034 Backpressure: SEND_VALID=1, SEND_READY=0 for 5 cycles -> SEND_DATA/SEND_INDEX constant, RECEIVE_READY=000; on SEND_READY=1 the next packet loads the same cycle.
REQ-035 Single port 2 streaming 10 packets with SEND_READY=1 -> 10 packets on 10 consecutive cycles, SEND_INDEX=2, data in order.
REQ-036 RST asserted while SEND_VALID=1 -> SEND_VALID=0 immediately (before next edge); after release, priority restarts at port 0.
